// File: rtl/mem_router.sv
// mem_router: address-decoding request router. One upstream request stream
// goes out to CNT downstream ports, and their responses come back in request
// order. A small FIFO of target indices (tags) keeps that order.
// Optional feature macro: MEM_ROUTER_DECERR_EN. When it is defined,
// out-of-range selects are answered locally with DECERR_DATA. When it is not
// defined, they are routed to the last slave.
module mem_router #(
   parameter int unsigned           CNT         = 2,
   parameter int unsigned           QUEUE_DEPTH = 4,
   parameter int unsigned           ADDR_WIDTH  = 32,
   parameter int unsigned           DATA_WIDTH  = 32,
   parameter int unsigned           SEL_LSB     = 28,
   parameter logic [DATA_WIDTH-1:0] DECERR_DATA = 32'hDEADBEEF
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   // upstream request
   input  logic                                 master_req_valid_i,
   output logic                                 master_req_ready_o,
   input  logic [ADDR_WIDTH-1:0]                master_req_data_i,
   // upstream response
   output logic                                 master_resp_valid_o,
   input  logic                                 master_resp_ready_i,
   output logic [DATA_WIDTH-1:0]                master_resp_data_o,
   // downstream requests
   output logic [CNT-1:0]                       slave_req_valid_o,
   input  logic [CNT-1:0]                       slave_req_ready_i,
   output logic [CNT-1:0][ADDR_WIDTH-1:0]       slave_req_data_o,
   // downstream responses
   input  logic [CNT-1:0]                       slave_resp_valid_i,
   output logic [CNT-1:0]                       slave_resp_ready_o,
   input  logic [CNT-1:0][DATA_WIDTH-1:0]       slave_resp_data_i,
   // FIFO occupancy
   output logic [$clog2(QUEUE_DEPTH+1)-1:0]     outstanding_o
);

   localparam int unsigned SW = $clog2(CNT);
   localparam int unsigned PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
   localparam int unsigned CW = $clog2(QUEUE_DEPTH + 1);

   // tag FIFO state
   logic [SW-1:0] tag_idx_q [QUEUE_DEPTH];
`ifdef MEM_ROUTER_DECERR_EN
   logic          tag_err_q [QUEUE_DEPTH];
`endif
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   logic          full, empty;
   logic [SW-1:0] sel_idx, route_idx, head_idx;
   logic          in_range, decerr_req, head_err;
   logic          req_fire, resp_fire;

   assign full  = (count_q == CW'(QUEUE_DEPTH));
   assign empty = (count_q == '0);

   // decode
   assign sel_idx   = master_req_data_i[SEL_LSB +: SW];
   assign in_range  = (32'(sel_idx) < CNT);
   assign route_idx = in_range ? sel_idx : SW'(CNT - 1);
   assign head_idx  = tag_idx_q[rd_ptr_q];

`ifdef MEM_ROUTER_DECERR_EN
   assign decerr_req = !in_range;
   assign head_err   = tag_err_q[rd_ptr_q];
`else
   assign decerr_req = 1'b0;
   assign head_err   = 1'b0;
   logic unused_decerr;
   assign unused_decerr = ^DECERR_DATA;
`endif

   // the address goes to every port unchanged; only valid is steered
   assign slave_req_data_o = {CNT{master_req_data_i}};

   assign outstanding_o = rst_i ? '0 : count_q;

   // request steering: only the decoded slave sees valid, and nothing is offered when full
   always_comb begin
      slave_req_valid_o  = '0;
      master_req_ready_o = 1'b0;
      if (!rst_i && !full) begin
         if (decerr_req) begin
            master_req_ready_o = 1'b1;
         end else begin
            slave_req_valid_o[route_idx] = master_req_valid_i;
            master_req_ready_o           = slave_req_ready_i[route_idx];
         end
      end
   end

   // response selection: only the slave named by the head tag is connected upstream
   always_comb begin
      master_resp_valid_o = 1'b0;
      master_resp_data_o  = '0;
      slave_resp_ready_o  = '0;
      if (!rst_i && !empty) begin
         if (head_err) begin
            master_resp_valid_o = 1'b1;
            master_resp_data_o  = DECERR_DATA;
         end else begin
            master_resp_valid_o          = slave_resp_valid_i[head_idx];
            master_resp_data_o           = slave_resp_data_i[head_idx];
            slave_resp_ready_o[head_idx] = master_resp_ready_i;
         end
      end
   end

   assign req_fire  = master_req_valid_i && master_req_ready_o;
   assign resp_fire = master_resp_valid_o && master_resp_ready_i;

   // next pointer and count values for push/pop
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (req_fire)
         wr_ptr_d = (wr_ptr_q == PW'(QUEUE_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (resp_fire)
         rd_ptr_d = (rd_ptr_q == PW'(QUEUE_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      if (req_fire && !resp_fire)
         count_d = count_q + 1'b1;
      else if (!req_fire && resp_fire)
         count_d = count_q - 1'b1;
   end

   // pointer and count registers; reset drops every in-flight tag
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // tag storage; entries are only read when the count says they are valid
   always_ff @(posedge clk_i) begin
      if (req_fire) begin
         tag_idx_q[wr_ptr_q] <= route_idx;
`ifdef MEM_ROUTER_DECERR_EN
         tag_err_q[wr_ptr_q] <= decerr_req;
`endif
      end
   end

endmodule

// File: tb/tb_mem_router.sv
// Scoreboard bench for mem_router (CNT=3, QUEUE_DEPTH=4, SEL_LSB=28).
// Behavioural slaves answer each accepted request after a chosen latency.
module tb_mem_router;

   localparam int CNT = 3;
   localparam int QD  = 4;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic                  master_req_valid = 1'b0;
   logic                  master_req_ready;
   logic [31:0]           master_req_data = '0;
   logic                  master_resp_valid;
   logic                  mready = 1'b1;
   logic [31:0]           master_resp_data;
   logic [CNT-1:0]        slave_req_valid;
   logic [CNT-1:0]        sready = '1;
   logic [CNT-1:0][31:0]  slave_req_data;
   logic [CNT-1:0]        slave_resp_valid = '0;
   logic [CNT-1:0]        slave_resp_ready;
   logic [CNT-1:0][31:0]  slave_resp_data = '0;
   logic [2:0]            outstanding;

   always #5 clk = ~clk;

   mem_router #(
      .CNT(CNT), .QUEUE_DEPTH(QD), .ADDR_WIDTH(32), .DATA_WIDTH(32),
      .SEL_LSB(28), .DECERR_DATA(32'hDEADBEEF)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .master_req_valid_i(master_req_valid), .master_req_ready_o(master_req_ready),
      .master_req_data_i(master_req_data),
      .master_resp_valid_o(master_resp_valid), .master_resp_ready_i(mready),
      .master_resp_data_o(master_resp_data),
      .slave_req_valid_o(slave_req_valid), .slave_req_ready_i(sready),
      .slave_req_data_o(slave_req_data),
      .slave_resp_valid_i(slave_resp_valid), .slave_resp_ready_o(slave_resp_ready),
      .slave_resp_data_i(slave_resp_data),
      .outstanding_o(outstanding)
   );

   typedef struct { logic [31:0] data; int lat; } pay_t;
   typedef struct { logic [31:0] data; int due; } pend_t;

   pay_t        pay_q  [CNT][$];
   pend_t       pend_q [CNT][$];
   logic [31:0] exp_q  [$];
   int          cyc = 0;
   int          vectors = 0;
   int          miscompares = 0;
   logic        force_rv = 1'b0;
   logic [31:0] cur_exp;
   int          cur_tgt;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endfunction

   // monitor: scoreboard on master responses, slave models on request/response fires
   always @(negedge clk) begin
      pay_t p;
      cyc = cyc + 1;
      if (rst) begin
         exp_q.delete();
         for (int j = 0; j < CNT; j++) begin
            pay_q[j].delete();
            pend_q[j].delete();
         end
      end else begin
         if (master_resp_valid && mready) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL resp_unexpected: got %h, no response pending", master_resp_data);
            end else begin
               check("resp_data", master_resp_data, exp_q.pop_front());
            end
         end
         for (int j = 0; j < CNT; j++)
            if (slave_resp_valid[j] && slave_resp_ready[j] && pend_q[j].size() > 0)
               pend_q[j].delete(0);
         for (int j = 0; j < CNT; j++) begin
            if (slave_req_valid[j] && sready[j]) begin
               if (pay_q[j].size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL stray_req: slave %0d got %h, expected no request", j, slave_req_data[j]);
               end else begin
                  p = pay_q[j].pop_front();
                  pend_q[j].push_back('{p.data, cyc + p.lat - 1});
                  check("req_bcast", slave_req_data[j], master_req_data);
               end
            end
         end
      end
   end

   // slave response drivers
   always @(posedge clk) begin
      #2;
      for (int j = 0; j < CNT; j++) begin
         if (force_rv) begin
            slave_resp_valid[j] = 1'b1;
            slave_resp_data[j]  = 32'h0;
         end else if (pend_q[j].size() > 0 && pend_q[j][0].due <= cyc) begin
            slave_resp_valid[j] = 1'b1;
            slave_resp_data[j]  = pend_q[j][0].data;
         end else begin
            slave_resp_valid[j] = 1'b0;
            slave_resp_data[j]  = 32'h0;
         end
      end
   end

   task automatic start_req(input logic [31:0] addr, input logic [31:0] rdata, input int lat);
      logic [31:0] a;
      int idx;
      a   = addr;
      idx = int'(a[29:28]);
      if (idx < CNT) cur_tgt = idx;
`ifdef MEM_ROUTER_DECERR_EN
      else cur_tgt = CNT;
`else
      else cur_tgt = CNT - 1;
`endif
      if (cur_tgt < CNT) begin
         pay_q[cur_tgt].push_back('{rdata, lat});
         cur_exp = rdata;
      end else begin
         cur_exp = 32'hDEADBEEF;
      end
      master_req_valid = 1'b1;
      master_req_data  = addr;
   endtask

   task automatic finish_req(output int stalls);
      stalls = 0;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (master_req_valid && master_req_ready) begin
            exp_q.push_back(cur_exp);
            check("req_route", 32'(slave_req_valid),
                  (cur_tgt < CNT) ? (32'd1 << cur_tgt) : 32'd0);
            @(posedge clk); #1;
            master_req_valid = 1'b0;
            return;
         end
         stalls++;
         @(posedge clk); #1;
      end
      vectors++;
      miscompares++;
      $display("FAIL req_timeout: request %h not accepted, expected acceptance", master_req_data);
      master_req_valid = 1'b0;
   endtask

   task automatic send(input logic [31:0] addr, input logic [31:0] rdata, input int lat, output int stalls);
      start_req(addr, rdata, lat);
      finish_req(stalls);
   endtask

   task automatic wait_drain(input string name);
      for (int n = 0; n < 300; n++) begin
         if (exp_q.size() == 0 && outstanding == 3'd0) begin
            check({name, "_idle"}, 32'(outstanding), 32'd0);
            return;
         end
         @(posedge clk); #1;
      end
      vectors++;
      miscompares++;
      $display("FAIL %s_drain: %0d responses still pending, expected 0", name, exp_q.size());
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_req_ready"},  32'(master_req_ready),  32'd0);
      check({name, "_slv_valid"},  32'(slave_req_valid),   32'd0);
      check({name, "_resp_valid"}, 32'(master_resp_valid), 32'd0);
      check({name, "_slv_ready"},  32'(slave_resp_ready),  32'd0);
      check({name, "_outst"},      32'(outstanding),       32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int st, tot, t0;
      bit found;

      // reset with traffic offered on every side
      force_rv         = 1'b1;
      master_req_valid = 1'b1;
      master_req_data  = 32'h1000_0000;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("rst_init");
      @(posedge clk); #1;
      rst = 1'b0; force_rv = 1'b0; master_req_valid = 1'b0;
      @(posedge clk); #1;

      // single request to slave1
      check("single_out0", 32'(outstanding), 32'd0);
      send(32'h1000_0040, 32'hA5A5_0001, 3, st);
      check("single_stall", 32'(st), 32'd0);
      check("single_out1", 32'(outstanding), 32'd1);
      wait_drain("single");

      // slow slave1 then fast slave0: slave0 must be held off
      send(32'h1000_0000, 32'h1111_0001, 5, st);
      send(32'h0000_0000, 32'h2222_0000, 1, st);
      found = 1'b0;
      for (int n = 0; n < 20 && !found; n++) begin
         @(negedge clk);
         if (slave_resp_valid[0] && pend_q[1].size() > 0) begin
            check("ooo_hold", 32'(slave_resp_ready[0]), 32'd0);
            found = 1'b1;
         end
      end
      if (!found) begin
         vectors++;
         miscompares++;
         $display("FAIL ooo_setup: slave0 never waited behind slave1, expected a held response");
      end
      @(posedge clk); #1;
      wait_drain("ooo");

      // full boundary
      mready = 1'b0;
      send(32'h0000_0010, 32'h3000_0001, 1, st);
      send(32'h1000_0020, 32'h3000_0002, 1, st);
      send(32'h0000_0030, 32'h3000_0003, 1, st);
      send(32'h1000_0040, 32'h3000_0004, 1, st);
      check("full_out4", 32'(outstanding), 32'd4);
      start_req(32'h0000_0050, 32'h3000_0005, 1);
      @(negedge clk);
      check("full_refuse", 32'(master_req_ready), 32'd0);
      check("full_no_valid", 32'(slave_req_valid), 32'd0);
      @(posedge clk); #1;
      mready = 1'b1;
      @(negedge clk);
      check("full_no_bypass", 32'(master_req_ready), 32'd0);
      @(posedge clk); #1;
      mready = 1'b0;
      check("full_out3", 32'(outstanding), 32'd3);
      finish_req(st);
      check("full_accept_next", 32'(st), 32'd0);
      mready = 1'b1;
      wait_drain("full");

      // streaming: 20 alternating requests, one per cycle
      tot = 0;
      t0  = cyc;
      for (int i = 0; i < 20; i++) begin
         send((i % 2 == 1) ? (32'h1000_0000 | 32'(i * 4)) : 32'(i * 4),
              32'h5000_0000 + 32'(i), 1, st);
         tot += st;
      end
      check("stream_stalls", 32'(tot), 32'd0);
      check("stream_cycles", 32'(cyc - t0), 32'd20);
      wait_drain("stream");

      // out-of-range select (idx 3 with CNT=3)
      send(32'h3000_0000, 32'h7777_0002, 2, st);
      wait_drain("decode");

      // reset with three requests in flight
      send(32'h0000_0100, 32'h8000_0001, 40, st);
      send(32'h1000_0200, 32'h8000_0002, 40, st);
      send(32'h2000_0300, 32'h8000_0003, 40, st);
      check("mid_out3", 32'(outstanding), 32'd3);
      rst = 1'b1; force_rv = 1'b1;
      master_req_valid = 1'b1; master_req_data = 32'h0000_0400;
      @(negedge clk);
      check_reset_outputs("rst_mid");
      @(posedge clk); #1;
      rst = 1'b0; force_rv = 1'b0; master_req_valid = 1'b0;
      check("mid_after", 32'(outstanding), 32'd0);
      @(posedge clk); #1;
      send(32'h1000_0500, 32'h9999_0001, 2, st);
      check("post_rst_out1", 32'(outstanding), 32'd1);
      wait_drain("post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
